// File: rtl/csel_subtractor_seq_pkg.sv
// rtl/csel_subtractor_seq_pkg.sv - shared state encoding and default sizes for the sliced subtractor
package csel_subtractor_seq_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SLICE = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csel_sub_slice.sv
// rtl/csel_sub_slice.sv - one carry-select subtract slice, both borrow cases precomputed then muxed
module csel_sub_slice
    import csel_subtractor_seq_pkg::*;
#(
    parameter int SLICE = DEF_SLICE
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             borrow_i,
    output logic [SLICE-1:0] d_s,
    output logic             borrow_o
);

    logic [SLICE:0] sum_nb;
    logic [SLICE:0] sum_b;

    // a - b is a + ~b + carry, where carry is the inverse of the incoming borrow
    assign sum_nb = {1'b0, a_s} + {1'b0, ~b_s} + {{SLICE{1'b0}}, 1'b1};
    assign sum_b  = {1'b0, a_s} + {1'b0, ~b_s};

    assign d_s      = borrow_i ? sum_b[SLICE-1:0] : sum_nb[SLICE-1:0];
    assign borrow_o = borrow_i ? ~sum_b[SLICE]    : ~sum_nb[SLICE];

endmodule

// File: rtl/csel_subtractor_seq.sv
// rtl/csel_subtractor_seq.sv - multi-cycle a - b - b_in, one carry-select slice per clock, valid/ready wrapped
module csel_subtractor_seq
    import csel_subtractor_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SLICE = DEF_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICES - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_width
        $error("csel_subtractor_seq: WIDTH must be a multiple of SLICE");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              borrow_q, borrow_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic              b_out_q, b_out_d;
    logic              ovf_q, ovf_d;

    int                off;
    logic [SLICE-1:0]  d_s;
    logic              borrow_o;

    assign off = int'(idx_q) * SLICE;

    csel_sub_slice #(.SLICE(SLICE)) u_slice (
        .a_s      (a_q[off +: SLICE]),
        .b_s      (b_q[off +: SLICE]),
        .borrow_i (borrow_q),
        .d_s      (d_s),
        .borrow_o (borrow_o)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = CALC;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in;
                    idx_d    = '0;
                end
            end
            CALC: begin
                diff_d[off +: SLICE] = d_s;
                borrow_d             = borrow_o;
                // The last slice also produces the top diff bit needed for overflow
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    b_out_d = borrow_o;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_s[SLICE-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign b_out     = b_out_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_subtractor_seq.sv
// tb/tb_csel_subtractor_seq.sv - scoreboard bench for csel_subtractor_seq with directed and random operands
module tb_csel_subtractor_seq;

    localparam int W  = 32;
    localparam int NS = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         b_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         b_out;
    logic         ovf;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rand_mode = 1'b0;
    bit   hold_val = 1'b1;
    bit   seen = 1'b0;

    csel_subtractor_seq #(.WIDTH(W), .SLICE(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain modular arithmetic and an unsigned magnitude compare
    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi);
        exp_t         e;
        logic [W:0]   full;
        full  = {1'b0, aa} - {1'b0, bb} - (W+1)'(bi);
        e.d   = full[W-1:0];
        e.bo  = ({1'b0, aa} < ({1'b0, bb} + (W+1)'(bi)));
        e.ov  = (aa[W-1] != bb[W-1]) && (e.d[W-1] != aa[W-1]);
        e.acc = 0;
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic bi,
                         input bit push, input logic [W-1:0] ed, input logic eb, input logic eo);
        bit ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("in_ready_wait", 64'(ok), 64'd1);
        a = aa;
        b = bb;
        b_in = bi;
        in_valid = 1'b1;
        if (push) begin
            e.d = ed; e.bo = eb; e.ov = eo; e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : hold_val;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got diff %0h with empty scoreboard, expected no result", diff);
                end else begin
                    e = sb.pop_front();
                    check("diff", 64'(diff), 64'(e.d));
                    check("b_out", 64'(b_out), 64'(e.bo));
                    check("ovf", 64'(ovf), 64'(e.ov));
                    check("latency", 64'(cyc - e.acc), 64'(NS));
                end
            end else if (!out_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        logic [W-1:0] ra, rb;
        logic rbi;
        bit ok;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_diff", 64'(diff), 64'd0);
        check("rst_b_out", 64'(b_out), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst_n = 1'b1;

        issue(32'd12, 32'd8, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0);
        issue(32'd2, 32'd8, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b1, 1'b0);
        issue(32'd233, 32'd108, 1'b1, 1'b1, 32'd124, 1'b0, 1'b0);
        issue(32'd0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        issue(32'h0000_FF00, 32'h0000_0100, 1'b0, 1'b1, 32'h0000_FE00, 1'b0, 1'b0);
        wait_drain();

        // Backpressure: result held, new operands refused
        hold_val = 1'b0;
        issue(32'd602, 32'd231, 1'b0, 1'b1, 32'd371, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("hold_valid_wait", 64'(ok), 64'd1);
        a = 32'd99; b = 32'd1; b_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_diff", 64'(diff), 64'd371);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        hold_val = 1'b1;
        repeat (12) @(negedge clk);
        check("post_hold_out_valid", 64'(out_valid), 64'd0);
        check("post_hold_in_ready", 64'(in_ready), 64'd1);
        check("post_hold_sb_empty", 64'(sb.size()), 64'd0);

        // Reset two cycles into CALC
        issue(32'd5, 32'd1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_diff", 64'(diff), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(32'd7, 32'd3, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0);
        wait_drain();

        // Random operands with random consumer stalls
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rbi = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: ra = {1'b1, 31'($urandom)};
                2: rb = {24'h0, 8'($urandom)};
                default: ;
            endcase
            e = model(ra, rb, rbi);
            issue(ra, rb, rbi, 1'b1, e.d, e.bo, e.ov);
        end
        wait_drain();
        rand_mode = 1'b0;
        hold_val = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
